// File: rtl/cell_write_ctrl_pkg.sv
// cell_write_ctrl shared types and constants
// FSM encoding, error codes, board helpers
package cell_write_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREDICT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_COORD   = 3'd1;
  localparam logic [2:0] ERR_DIGIT   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_LOCKED  = 3'd4;

  localparam int BOARD_DIM = 9;

  function automatic logic coord_ok(
    input logic [3:0] v
  );
    return v < 4'(BOARD_DIM);
  endfunction

  function automatic logic digit_ok(
    input logic [3:0] d
  );
    return (d != 4'd0) && (d <= 4'(BOARD_DIM));
  endfunction

  function automatic logic [6:0] cell_idx(
    input logic [3:0] row,
    input logic [3:0] col
  );
    return 7'(int'(row) * BOARD_DIM + int'(col));
  endfunction

endpackage

// File: rtl/cell_write_ctrl_timer.sv
// cwc_timer: loadable down-counter, stops at 0
// ports: clk, rst(n), load, load_val, en, zero
module cwc_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cell_write_ctrl.sv
// cell_write_ctrl: track -> predict -> write FSM
// in: clk rst enable track_valid block_x/y cell_blank
//     pred_done pred_digit
// out: pred_start wr_pulse wr_row/col/data busy
//      err_code wr_count
// option: CELL_WRITE_GIVEN_LOCK_EN blocks given cells
module cell_write_ctrl
  import cell_write_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        track_valid,
  input  logic [3:0]  block_x,
  input  logic [3:0]  block_y,
  input  logic [80:0] cell_blank,
  output logic        pred_start,
  input  logic        pred_done,
  input  logic [3:0]  pred_digit,
  output logic        wr_pulse,
  output logic [3:0]  wr_row,
  output logic [3:0]  wr_col,
  output logic [3:0]  wr_data,
  output logic        busy,
  output logic [2:0]  err_code,
  output logic [7:0]  wr_count
);

  localparam int unsigned MAXC =
    (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ?
    TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int TW = $clog2(MAXC + 1);

  state_t state, state_n;

  logic          capture;
  logic          latch;
  logic          err_set;
  logic [2:0]    err_n;
  logic          cnt_inc;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_zero;

  cwc_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign tmr_en = (state == ST_PREDICT) ||
                  (state == ST_HOLDOFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    latch    = 1'b0;
    err_set  = 1'b0;
    err_n    = err_code;
    cnt_inc  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (track_valid) begin
            err_set = 1'b1;
            if (coord_ok(block_x) &&
                coord_ok(block_y)) begin
              capture  = 1'b1;
              err_n    = ERR_NONE;
              tmr_load = 1'b1;
              tmr_val  = TW'(TIMEOUT_CYCLES - 1);
              state_n  = ST_PREDICT;
            end else begin
              err_n = ERR_COORD;
            end
          end
        end
        ST_PREDICT: begin
          // pred_done wins over a same-cycle timeout
          if (pred_done) begin
            if (!digit_ok(pred_digit)) begin
              err_set = 1'b1;
              err_n   = ERR_DIGIT;
              state_n = ST_IDLE;
`ifdef CELL_WRITE_GIVEN_LOCK_EN
            end else if (!cell_blank[
                cell_idx(wr_row, wr_col)]) begin
              err_set = 1'b1;
              err_n   = ERR_LOCKED;
              state_n = ST_IDLE;
`endif
            end else begin
              latch   = 1'b1;
              state_n = ST_WRITE;
            end
          end else if (tmr_zero) begin
            err_set = 1'b1;
            err_n   = ERR_TIMEOUT;
            state_n = ST_IDLE;
          end
        end
        ST_WRITE: begin
          cnt_inc  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLDOFF_CYCLES - 1);
          state_n  = ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (tmr_zero) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

`ifndef CELL_WRITE_GIVEN_LOCK_EN
  logic unused_blank;
  assign unused_blank = ^cell_blank;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_start <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_data    <= '0;
      err_code   <= ERR_NONE;
      wr_count   <= '0;
    end else begin
      pred_start <= capture;
      if (capture) begin
        wr_row <= block_y;
        wr_col <= block_x;
      end
      if (latch)   wr_data  <= pred_digit;
      if (err_set) err_code <= err_n;
      if (cnt_inc && (wr_count != 8'hFF))
        wr_count <= wr_count + 8'd1;
    end
  end

  // enable low in WRITE suppresses the strobe
  assign wr_pulse = (state == ST_WRITE) && enable;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_cell_write_ctrl.sv
// tb_cell_write_ctrl: directed scenarios
// scoreboard queue of expected writes + monitor
module tb_cell_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        track_valid = 1'b0;
  logic [3:0]  block_x = '0;
  logic [3:0]  block_y = '0;
  logic [80:0] cell_blank = '1;
  logic        pred_start;
  logic        pred_done = 1'b0;
  logic [3:0]  pred_digit = '0;
  logic        wr_pulse;
  logic [3:0]  wr_row;
  logic [3:0]  wr_col;
  logic [3:0]  wr_data;
  logic        busy;
  logic [2:0]  err_code;
  logic [7:0]  wr_count;

  cell_write_ctrl #(
    .TIMEOUT_CYCLES(16),
    .HOLDOFF_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .track_valid (track_valid),
    .block_x     (block_x),
    .block_y     (block_y),
    .cell_blank  (cell_blank),
    .pred_start  (pred_start),
    .pred_done   (pred_done),
    .pred_digit  (pred_digit),
    .wr_pulse    (wr_pulse),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .busy        (busy),
    .err_code    (err_code),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s act=%0d exp=%0d t=%0t",
                  name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst && wr_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_wr row=%0d col=%0d data=%0d cyc=%0d",
                 wr_row, wr_col, wr_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_row", 32'(wr_row), 32'(e.row));
        chk("wr_col", 32'(wr_col), 32'(e.col));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic track(input logic [3:0] x,
                       input logic [3:0] y,
                       input logic acc);
    track_valid = 1'b1;
    block_x = x;
    block_y = y;
    @(negedge clk);
    track_valid = 1'b0;
    chk("pred_start", 32'(pred_start), 32'(acc));
  endtask

  task automatic done(input logic [3:0] d,
                      input logic wr,
                      input logic [3:0] row,
                      input logic [3:0] col);
    exp_t e;
    pred_done = 1'b1;
    pred_digit = d;
    if (wr) begin
      e.row = row;
      e.col = col;
      e.data = d;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    pred_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pstart", 32'(pred_start), 0);
    chk("rst_wr", 32'(wr_pulse), 0);
    chk("rst_err", 32'(err_code), 0);
    chk("rst_cnt", 32'(wr_count), 0);
    chk("rst_row", 32'(wr_row), 0);
    rst = 1'b1;
    enable = 1'b1;
    tick(1);

    // nominal + holdoff
    track(3, 5, 1);
    chk("busy_pred", 32'(busy), 1);
    tick(1);
    chk("pstart_pulse", 32'(pred_start), 0);
    tick(8);
    done(7, 1, 5, 3);
    tick(1);
    chk("cnt1", 32'(wr_count), 1);
    chk("err_nom", 32'(err_code), 0);
    tick(1);
    track(1, 2, 0);
    tick(1);
    chk("busy_ho_last", 32'(busy), 1);
    tick(1);
    chk("busy_ho_end", 32'(busy), 0);
    tick(1);
    track(1, 2, 1);
    done(9, 1, 2, 1);
    tick(6);
    chk("cnt2", 32'(wr_count), 2);

    // bad coordinates and digits
    track(9, 2, 0);
    chk("err_x9", 32'(err_code), 1);
    chk("busy_x9", 32'(busy), 0);
    track(2, 9, 0);
    chk("err_y9", 32'(err_code), 1);
    track(8, 8, 1);
    chk("err_clear", 32'(err_code), 0);
    done(0, 0, 0, 0);
    chk("err_d0", 32'(err_code), 2);
    chk("busy_d0", 32'(busy), 0);
    track(0, 0, 1);
    chk("err_clear2", 32'(err_code), 0);
    done(10, 0, 0, 0);
    chk("err_d10", 32'(err_code), 2);
    tick(2);
    chk("cnt_bad", 32'(wr_count), 2);

    // timeout
    track(4, 1, 1);
    tick(15);
    chk("busy_to15", 32'(busy), 1);
    tick(2);
    chk("err_to", 32'(err_code), 3);
    chk("busy_to17", 32'(busy), 0);
    track(6, 7, 1);
    tick(15);
    done(5, 1, 7, 6);
    tick(6);
    chk("cnt_to", 32'(wr_count), 3);

    // abort via enable
    track(2, 2, 1);
    tick(3);
    enable = 1'b0;
    tick(1);
    chk("busy_abort", 32'(busy), 0);
    enable = 1'b1;
    done(4, 0, 0, 0);
    tick(3);
    chk("busy_late", 32'(busy), 0);
    chk("cnt_abort", 32'(wr_count), 3);
    chk("err_abort", 32'(err_code), 0);

    // given-cell lock
    cell_blank = '1;
    cell_blank[40] = 1'b0;
`ifdef CELL_WRITE_GIVEN_LOCK_EN
    track(4, 4, 1);
    done(2, 0, 0, 0);
    chk("err_lock", 32'(err_code), 4);
    chk("busy_lock", 32'(busy), 0);
    tick(2);
    chk("cnt_lock", 32'(wr_count), 3);
`else
    track(4, 4, 1);
    done(2, 1, 4, 4);
    tick(1);
    chk("cnt_nolock", 32'(wr_count), 4);
    chk("err_nolock", 32'(err_code), 0);
    tick(5);
`endif
    cell_blank = '1;

    // reset during holdoff
    track(1, 1, 1);
    done(3, 1, 1, 1);
    tick(2);
    chk("busy_ho", 32'(busy), 1);
`ifdef CELL_WRITE_GIVEN_LOCK_EN
    chk("cnt_pre_rst", 32'(wr_count), 4);
`else
    chk("cnt_pre_rst", 32'(wr_count), 5);
`endif
    #1;
    rst = 1'b0;
    #1;
    chk("async_cnt", 32'(wr_count), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_row", 32'(wr_row), 0);
    @(negedge clk);
    rst = 1'b1;
    tick(6);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_cnt", 32'(wr_count), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cell_write_ctrl.md
CELL_WRITE_CTRL -- requirements
Module: cell_write_ctrl

Interface
REQ-001 SHALL have parameters: TIMEOUT_CYCLES, 1_000_000, max clk cycles waiting for pred_done; HOLDOFF_CYCLES, 1024, post-write cycles during which new tracks are ignored.
REQ-002 SHALL have ports in this order, each as name / direction / width / meaning:
- clk / in / 1 / system clock; one clock domain.
- rst / in / 1 / asynchronous, active-low reset.
- enable / in / 1 / high while game state is active.
- track_valid / in / 1 / one-cycle pulse from the drawing stage; a digit stroke is complete.
- block_x / in / 4 / column of the drawn cell.
- block_y / in / 4 / row of the drawn cell.
- cell_blank / in / 81 / initial-board blank map; bit index = row*9+col; 1 = editable.
- pred_start / out / 1 / one-cycle pulse that starts the digit predictor.
- pred_done / in / 1 / one-cycle pulse; prediction is valid.
- pred_digit / in / 4 / predicted digit, sampled when pred_done is high.
- wr_pulse / out / 1 / one-cycle write strobe to the solver.
- wr_row / out / 4 / captured row.
- wr_col / out / 4 / captured column.
- wr_data / out / 4 / digit being written.
- busy / out / 1 / high in any state other than IDLE.
- err_code / out / 3 / last error code.
- wr_count / out / 8 / saturating count of writes issued.

Function
REQ-003 SHALL implement the FSM states IDLE, PREDICT, WRITE and HOLDOFF.
REQ-004 In IDLE, when track_valid & enable and block_x<=8 and block_y<=8, the block SHALL:
- capture the coordinates into wr_row/wr_col;
- assert pred_start in the next cycle;
- enter PREDICT;
- clear err_code to 0.
REQ-005 In IDLE, track_valid & enable with either coordinate >8 SHALL set err_code=1, produce no pred_start and stay in IDLE.
REQ-006 In PREDICT, on pred_done with pred_digit in 1..9, the block SHALL latch wr_data and enter WRITE.
REQ-007 In PREDICT, on pred_done with pred_digit equal to 0 or >9, the block SHALL set err_code=2 and return to IDLE without writing.
REQ-008 In PREDICT, the wait counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYCLES-1 without pred_done, the block SHALL set err_code=3 and enter IDLE.
REQ-009 If pred_done and the timeout occur in the same cycle, pred_done SHALL take priority.
REQ-010 WRITE SHALL last exactly one cycle with wr_pulse=1, then enter HOLDOFF. wr_count SHALL increment and saturate at 255.
REQ-011 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles, then enter IDLE.
REQ-012 track_valid outside IDLE SHALL be ignored and not queued.
REQ-013 pred_done outside PREDICT SHALL be ignored.
REQ-014 If enable deasserts in any state, the FSM SHALL go to IDLE on the next edge with no wr_pulse; err_code and wr_count SHALL be unchanged.
REQ-015 Latency from track_valid to pred_start SHALL be 1 cycle. Latency from pred_done to wr_pulse SHALL be 1 cycle.
REQ-016 wr_row, wr_col and wr_data SHALL hold their values until the next capture.

Reset
REQ-017 While rst=0, the block SHALL hold:
- state=IDLE;
- all outputs 0, including wr_count=0 and err_code=0;
- counters cleared.
REQ-018 Reset asserted in the middle of an operation SHALL abort the operation immediately, with no wr_pulse on the release cycle.

Configuration
REQ-019 With macro CELL_WRITE_GIVEN_LOCK_EN defined:
- in the WRITE-entry decision, if cell_blank[wr_row*9+wr_col]==0, the block SHALL set err_code=4, return to IDLE and produce no wr_pulse;
- wr_count SHALL be unchanged in that case.
REQ-020 Without CELL_WRITE_GIVEN_LOCK_EN, cell_blank SHALL be ignored and err_code value 4 SHALL never occur.

Structure
REQ-021 A shared package SHALL hold:
- the FSM state encoding (2 bits);
- the err_code constants ERR_NONE=0, ERR_COORD=1, ERR_DIGIT=2, ERR_TIMEOUT=3, ERR_LOCKED=4;
- the board dimension constant 9.
REQ-022 One sub-module, cwc_timer, SHALL provide a loadable down-counter shared by the PREDICT timeout and the HOLDOFF duration.

Verification
REQ-023 The bench SHALL cover these directed scenarios (TIMEOUT_CYCLES=16 and HOLDOFF_CYCLES=4 where noted):
- Nominal: track_valid with (x=3, y=5), then pred_done with digit 7 after 10 cycles. Required: pred_start 1 cycle after track_valid; wr_pulse 1 cycle after pred_done with wr_row=5, wr_col=3, wr_data=7; wr_count=1.
- Bad inputs: block_x=9 gives err_code=1 and no pred_start. pred_digit=0 gives err_code=2 and no wr_pulse.
- Timeout (TIMEOUT_CYCLES=16): no pred_done gives err_code=3 and busy low at cycle 17 after pred_start. With pred_done coinciding with the timeout, a write occurs.
- Holdoff (HOLDOFF_CYCLES=4): a second track_valid 2 cycles after wr_pulse is ignored. A third track_valid 6 cycles after wr_pulse is accepted.
- Abort: enable drops during PREDICT, then a late pred_done arrives, giving no wr_pulse. rst pulled low in HOLDOFF clears wr_count to 0 asynchronously.
- Lock (macro defined): cell_blank[40]=0 with (x=4, y=4) and digit 2 gives err_code=4 and no wr_pulse. Without the macro, the same stimulus writes.
